// File: rtl/multicycle_ctrl_wait.sv
// Multicycle CPU control FSM with memory wait states, DECODE stall,
// illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl_wait #(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                MemReady,
    input  logic                Stall,
    output logic                MemReq,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MDRWrite,
    output logic                PCWrite,
    output logic                RegWrite,
    output logic                Beq,
    output logic                Bne,
    output logic [1:0]          IorD,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUSrc1,
    output logic [1:0]          ALUSrc2,
    output logic [1:0]          ALUoutSrc,
    output logic [2:0]          ALUOp,
    output logic [2:0]          RegSrc,
    output logic [4:0]          current_state,
    output logic                Trap,
    output logic [CNT_W-1:0]    InstrCount
);

    typedef enum logic [4:0] {
        FETCH    = 5'd0,
        DECODE   = 5'd1,
        R_EXEC   = 5'd2,
        R_WRITE  = 5'd3,
        ADDR     = 5'd4,
        LW_MEM   = 5'd5,
        SW_MEM   = 5'd6,
        LW_WB    = 5'd7,
        JR       = 5'd9,
        BR_EXEC  = 5'd10,
        BNE_DONE = 5'd11,
        BEQ_DONE = 5'd12,
        JAL      = 5'd13,
        I_EXEC   = 5'd14,
        I_WRITE  = 5'd15,
        LUI      = 5'd16,
        LI       = 5'd17,
        TRAP     = 5'd18
    } state_t;

    state_t     state, nxt;
    logic [3:0] op4;
    logic       op_ill;

    // Any bit above the 4-bit ISA field makes the opcode illegal.
    assign op4    = Opcode[3:0];
    assign op_ill = ((Opcode >> 4) != '0);

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:    nxt = MemReady ? DECODE : FETCH;
            DECODE: begin
                if (Stall)       nxt = DECODE;
                else if (op_ill) nxt = TRAP;
                else begin
                    case (op4)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4: nxt = R_EXEC;
                        4'd5:                         nxt = JR;
                        4'd6, 4'd10:                  nxt = ADDR;
                        4'd7:                         nxt = JAL;
                        4'd8, 4'd9:                   nxt = BR_EXEC;
                        4'd11, 4'd12, 4'd13:          nxt = I_EXEC;
                        4'd14:                        nxt = LUI;
                        4'd15:                        nxt = LI;
                        default:                      nxt = TRAP;
                    endcase
                end
            end
            R_EXEC:   nxt = R_WRITE;
            R_WRITE:  nxt = FETCH;
            ADDR: begin
                if (!op_ill && op4 == 4'd6)       nxt = SW_MEM;
                else if (!op_ill && op4 == 4'd10) nxt = LW_MEM;
                else                              nxt = TRAP;
            end
            LW_MEM:   nxt = MemReady ? LW_WB : LW_MEM;
            SW_MEM:   nxt = MemReady ? FETCH : SW_MEM;
            LW_WB:    nxt = FETCH;
            JR:       nxt = FETCH;
            BR_EXEC: begin
                if (!op_ill && op4 == 4'd8)      nxt = BEQ_DONE;
                else if (!op_ill && op4 == 4'd9) nxt = BNE_DONE;
                else                             nxt = TRAP;
            end
            BNE_DONE: nxt = FETCH;
            BEQ_DONE: nxt = FETCH;
            JAL:      nxt = FETCH;
            I_EXEC: begin
                if (!op_ill && (op4 == 4'd11 || op4 == 4'd12 || op4 == 4'd13))
                    nxt = I_WRITE;
                else
                    nxt = TRAP;
            end
            I_WRITE:  nxt = FETCH;
            LUI:      nxt = FETCH;
            LI:       nxt = FETCH;
            TRAP:     nxt = TRAP;
            default:  nxt = FETCH;
        endcase
    end

    // Retirement is any return to FETCH; TRAP never returns, so it never counts.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= FETCH;
            InstrCount <= '0;
        end else begin
            state <= nxt;
            if (nxt == FETCH && state != FETCH)
                InstrCount <= InstrCount + CNT_W'(1);
        end
    end

    always_comb begin
        MemReq    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        MDRWrite  = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        Beq       = 1'b0;
        Bne       = 1'b0;
        IorD      = 2'd0;
        PCSource  = 2'd0;
        ALUSrc1   = 2'd0;
        ALUSrc2   = 2'd0;
        ALUoutSrc = 2'd0;
        ALUOp     = 3'd0;
        RegSrc    = 3'd0;
        Trap      = 1'b0;
        case (state)
            FETCH: begin
                MemReq    = 1'b1;
                MemRead   = 1'b1;
                ALUSrc1   = 2'd2;
                ALUSrc2   = 2'd2;
                ALUOp     = 3'd2;
                PCSource  = 2'd1;
                ALUoutSrc = 2'd1;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            DECODE: begin
                ALUSrc1 = 2'd0;
                ALUSrc2 = 2'd2;
            end
            R_EXEC: begin
                ALUSrc1   = 2'd3;
                ALUSrc2   = 2'd0;
                ALUoutSrc = 2'd3;
                if (!op_ill) begin
                    case (op4)
                        4'd0:    ALUOp = 3'd2;
                        4'd1:    ALUOp = 3'd0;
                        4'd2:    ALUOp = 3'd1;
                        4'd3:    ALUOp = 3'd6;
                        4'd4:    ALUOp = 3'd7;
                        default: ALUOp = 3'd0;
                    endcase
                end
            end
            R_WRITE: begin
                RegWrite = 1'b1;
                RegSrc   = 3'd4;
            end
            ADDR:     ALUoutSrc = 2'd3;
            LW_MEM: begin
                MemReq   = 1'b1;
                MemRead  = 1'b1;
                IorD     = 2'd1;
                MDRWrite = MemReady;
            end
            SW_MEM: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                IorD     = 2'd1;
            end
            LW_WB: begin
                RegWrite = 1'b1;
                RegSrc   = 3'd1;
            end
            JR: begin
                PCWrite  = 1'b1;
                PCSource = 2'd1;
                IorD     = 2'd2;
            end
            BR_EXEC: begin
                ALUSrc1 = 2'd1;
                ALUSrc2 = 2'd0;
                ALUOp   = 3'd6;
            end
            BNE_DONE: begin
                PCWrite = 1'b1;
                Bne     = 1'b1;
            end
            BEQ_DONE: begin
                PCWrite = 1'b1;
                Beq     = 1'b1;
            end
            JAL: begin
                RegWrite = 1'b1;
                RegSrc   = 3'd3;
                PCWrite  = 1'b1;
                PCSource = 2'd2;
            end
            I_EXEC: begin
                ALUSrc1 = 2'd0;
                ALUSrc2 = 2'd0;
                if (!op_ill) begin
                    case (op4)
                        4'd11:   ALUOp = 3'd2;
                        4'd12:   ALUOp = 3'd0;
                        4'd13:   ALUOp = 3'd1;
                        default: ALUOp = 3'd0;
                    endcase
                end
            end
            I_WRITE: begin
                RegWrite = 1'b1;
                RegSrc   = 3'd4;
            end
            LUI: begin
                RegWrite = 1'b1;
                RegSrc   = 3'd2;
            end
            LI: begin
                RegWrite  = 1'b1;
                ALUoutSrc = 2'd2;
            end
            TRAP:     Trap = 1'b1;
            default: ;
        endcase
    end

    assign current_state = state;

endmodule

// File: tb/tb_multicycle_ctrl_wait.sv
// Table-driven bench for multicycle_ctrl_wait: a default instance plus a
// 5-bit-opcode / 2-bit-counter instance share the same stimulus.
module tb_multicycle_ctrl_wait;

    typedef struct packed {
        logic       memreq, memread, memwrite, irwrite, mdrwrite;
        logic       pcwrite, regwrite, beq, bne, trap;
        logic [1:0] iord, pcsource, alusrc1, alusrc2, aluoutsrc;
        logic [2:0] aluop, regsrc;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [4:0]  op;
        logic        rdy;
        logic        stl;
        logic [4:0]  st;
        logic [15:0] cnt;
        logic        c1;
        logic        c2;
    } vec_t;

    typedef struct {
        int          idx;
        logic        c1, c2;
        logic [4:0]  st;
        outs_t       o;
        logic [15:0] cnt;
    } exp_t;

    logic       CLK, Reset, MemReady, Stall;
    logic [4:0] opc;

    logic        MemReq_a, MemRead_a, MemWrite_a, IRWrite_a, MDRWrite_a, PCWrite_a;
    logic        RegWrite_a, Beq_a, Bne_a, Trap_a;
    logic [1:0]  IorD_a, PCSource_a, ALUSrc1_a, ALUSrc2_a, ALUoutSrc_a;
    logic [2:0]  ALUOp_a, RegSrc_a;
    logic [4:0]  st_a;
    logic [15:0] cnt_a;

    logic        MemReq_b, MemRead_b, MemWrite_b, IRWrite_b, MDRWrite_b, PCWrite_b;
    logic        RegWrite_b, Beq_b, Bne_b, Trap_b;
    logic [1:0]  IorD_b, PCSource_b, ALUSrc1_b, ALUSrc2_b, ALUoutSrc_b;
    logic [2:0]  ALUOp_b, RegSrc_b;
    logic [4:0]  st_b;
    logic [1:0]  cnt_b;

    outs_t act_a, act_b;
    assign act_a = {MemReq_a, MemRead_a, MemWrite_a, IRWrite_a, MDRWrite_a, PCWrite_a,
                    RegWrite_a, Beq_a, Bne_a, Trap_a, IorD_a, PCSource_a, ALUSrc1_a,
                    ALUSrc2_a, ALUoutSrc_a, ALUOp_a, RegSrc_a};
    assign act_b = {MemReq_b, MemRead_b, MemWrite_b, IRWrite_b, MDRWrite_b, PCWrite_b,
                    RegWrite_b, Beq_b, Bne_b, Trap_b, IorD_b, PCSource_b, ALUSrc1_b,
                    ALUSrc2_b, ALUoutSrc_b, ALUOp_b, RegSrc_b};

    multicycle_ctrl_wait dut (
        .CLK(CLK), .Reset(Reset), .Opcode(opc[3:0]), .MemReady(MemReady), .Stall(Stall),
        .MemReq(MemReq_a), .MemRead(MemRead_a), .MemWrite(MemWrite_a),
        .IRWrite(IRWrite_a), .MDRWrite(MDRWrite_a), .PCWrite(PCWrite_a),
        .RegWrite(RegWrite_a), .Beq(Beq_a), .Bne(Bne_a), .IorD(IorD_a),
        .PCSource(PCSource_a), .ALUSrc1(ALUSrc1_a), .ALUSrc2(ALUSrc2_a),
        .ALUoutSrc(ALUoutSrc_a), .ALUOp(ALUOp_a), .RegSrc(RegSrc_a),
        .current_state(st_a), .Trap(Trap_a), .InstrCount(cnt_a)
    );

    multicycle_ctrl_wait #(.OPCODE_W(5), .CNT_W(2)) dut2 (
        .CLK(CLK), .Reset(Reset), .Opcode(opc), .MemReady(MemReady), .Stall(Stall),
        .MemReq(MemReq_b), .MemRead(MemRead_b), .MemWrite(MemWrite_b),
        .IRWrite(IRWrite_b), .MDRWrite(MDRWrite_b), .PCWrite(PCWrite_b),
        .RegWrite(RegWrite_b), .Beq(Beq_b), .Bne(Bne_b), .IorD(IorD_b),
        .PCSource(PCSource_b), .ALUSrc1(ALUSrc1_b), .ALUSrc2(ALUSrc2_b),
        .ALUoutSrc(ALUoutSrc_b), .ALUOp(ALUOp_b), .RegSrc(RegSrc_b),
        .current_state(st_b), .Trap(Trap_b), .InstrCount(cnt_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference output table for each state.
    function automatic outs_t exp_outs(input logic [4:0] st, input logic [4:0] op,
                                       input logic rdy);
        outs_t o;
        o = '0;
        case (st)
            5'd0: begin
                o.memreq = 1; o.memread = 1; o.alusrc1 = 2; o.alusrc2 = 2; o.aluop = 2;
                o.pcsource = 1; o.aluoutsrc = 1; o.irwrite = rdy; o.pcwrite = rdy;
            end
            5'd1:  begin o.alusrc1 = 0; o.alusrc2 = 2; end
            5'd2: begin
                o.alusrc1 = 3; o.alusrc2 = 0; o.aluoutsrc = 3;
                case (op)
                    5'd0: o.aluop = 2; 5'd1: o.aluop = 0; 5'd2: o.aluop = 1;
                    5'd3: o.aluop = 6; 5'd4: o.aluop = 7; default: o.aluop = 0;
                endcase
            end
            5'd3:  begin o.regwrite = 1; o.regsrc = 4; end
            5'd4:  o.aluoutsrc = 3;
            5'd5:  begin o.memreq = 1; o.memread = 1; o.iord = 1; o.mdrwrite = rdy; end
            5'd6:  begin o.memreq = 1; o.memwrite = 1; o.iord = 1; end
            5'd7:  begin o.regwrite = 1; o.regsrc = 1; end
            5'd9:  begin o.pcwrite = 1; o.pcsource = 1; o.iord = 2; end
            5'd10: begin o.alusrc1 = 1; o.alusrc2 = 0; o.aluop = 6; end
            5'd11: begin o.pcwrite = 1; o.bne = 1; end
            5'd12: begin o.pcwrite = 1; o.beq = 1; end
            5'd13: begin o.regwrite = 1; o.regsrc = 3; o.pcwrite = 1; o.pcsource = 2; end
            5'd14: begin
                case (op)
                    5'd11: o.aluop = 2; 5'd12: o.aluop = 0; 5'd13: o.aluop = 1;
                    default: o.aluop = 0;
                endcase
            end
            5'd15: begin o.regwrite = 1; o.regsrc = 4; end
            5'd16: begin o.regwrite = 1; o.regsrc = 2; end
            5'd17: begin o.regwrite = 1; o.aluoutsrc = 2; end
            5'd18: o.trap = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic add(input logic rst, input int op, input logic rdy, input logic stl,
                       input int st, input int cnt, input logic c1 = 1, input logic c2 = 1);
        vec_t v;
        v.rst = rst; v.op = 5'(op); v.rdy = rdy; v.stl = stl;
        v.st = 5'(st); v.cnt = 16'(cnt); v.c1 = c1; v.c2 = c2;
        vecs.push_back(v);
    endtask

    task automatic rst_vec();
        add(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, got, want);
        end
    endtask

    initial begin
        int c;
        exp_t e;
        Reset = 1'b1; opc = '0; MemReady = 1'b0; Stall = 1'b0;

        // R-type op0 with ready memory, then ops 1-4, I-type, LUI, LI, JAL, JR
        rst_vec();
        add(0, 0, 1, 0, 0, 0); add(0, 0, 0, 0, 1, 0); add(0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 3, 0); add(0, 0, 0, 0, 0, 1);
        c = 1;
        for (int op = 1; op <= 4; op++) begin
            add(0, op, 1, 0, 0, c); add(0, op, 0, 0, 1, c);
            add(0, op, 0, 0, 2, c); add(0, op, 0, 0, 3, c); c++;
        end
        for (int op = 11; op <= 13; op++) begin
            add(0, op, 1, 0, 0, c); add(0, op, 0, 0, 1, c);
            add(0, op, 0, 0, 14, c); add(0, op, 0, 0, 15, c); c++;
        end
        add(0, 14, 1, 0, 0, c); add(0, 14, 0, 0, 1, c); add(0, 14, 0, 0, 16, c); c++;
        add(0, 15, 1, 0, 0, c); add(0, 15, 0, 0, 1, c); add(0, 15, 0, 0, 17, c); c++;
        add(0, 7, 1, 0, 0, c);  add(0, 7, 0, 0, 1, c);  add(0, 7, 0, 0, 13, c); c++;
        add(0, 5, 1, 0, 0, c);  add(0, 5, 0, 0, 1, c);  add(0, 5, 0, 0, 9, c); c++;
        add(0, 0, 0, 0, 0, c);

        // LW with 3 fetch waits and 2 memory waits: 10 cycles
        rst_vec();
        for (int i = 0; i < 3; i++) add(0, 10, 0, 0, 0, 0);
        add(0, 10, 1, 0, 0, 0); add(0, 10, 1, 0, 1, 0); add(0, 10, 1, 0, 4, 0);
        add(0, 10, 0, 0, 5, 0); add(0, 10, 0, 0, 5, 0); add(0, 10, 1, 0, 5, 0);
        add(0, 10, 0, 0, 7, 0); add(0, 10, 0, 0, 0, 1);

        // SW with delayed ready
        rst_vec();
        add(0, 6, 1, 0, 0, 0); add(0, 6, 0, 0, 1, 0); add(0, 6, 0, 0, 4, 0);
        for (int i = 0; i < 3; i++) add(0, 6, 0, 0, 6, 0);
        add(0, 6, 1, 0, 6, 0); add(0, 6, 0, 0, 0, 1);

        // BNE then BEQ back to back
        rst_vec();
        add(0, 9, 1, 0, 0, 0); add(0, 9, 0, 0, 1, 0); add(0, 9, 0, 0, 10, 0);
        add(0, 9, 0, 0, 11, 0);
        add(0, 8, 1, 0, 0, 1); add(0, 8, 0, 0, 1, 1); add(0, 8, 0, 0, 10, 1);
        add(0, 8, 0, 0, 12, 1); add(0, 8, 0, 0, 0, 2);

        // Illegal opcode 20 on the 5-bit instance: sticky trap, cleared by Reset
        rst_vec();
        add(0, 20, 1, 0, 0, 0, 0, 1); add(0, 20, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            add(0, (i * 7) % 32, i % 2, (i % 3) == 0, 18, 0, 0, 1);
        rst_vec();
        add(0, 0, 0, 0, 0, 0);

        // Stall held 4 cycles in DECODE, then Reset aborts LW_MEM
        rst_vec();
        add(0, 10, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 10, 0, 1, 1, 0);
        add(0, 10, 0, 0, 1, 0); add(0, 10, 0, 1, 4, 0); add(0, 10, 0, 0, 5, 0);
        add(1, 10, 1, 0, 5, 0);
        add(0, 10, 0, 0, 0, 0);

        // Five JRs: 16-bit counter reads 5, 2-bit counter wraps to 1
        c = 0;
        for (int k = 0; k < 5; k++) begin
            add(0, 5, 1, 0, 0, c); add(0, 5, 0, 0, 1, c); add(0, 5, 0, 0, 9, c); c++;
        end
        add(0, 0, 0, 0, 0, c);

        foreach (vecs[i]) begin
            @(negedge CLK);
            Reset = vecs[i].rst; opc = vecs[i].op;
            MemReady = vecs[i].rdy; Stall = vecs[i].stl;
            e.idx = i; e.c1 = vecs[i].c1; e.c2 = vecs[i].c2; e.st = vecs[i].st;
            e.cnt = vecs[i].cnt;
            e.o = exp_outs(vecs[i].st, vecs[i].op, vecs[i].rdy);
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            if (e.c1) begin
                chk("state_a", e.idx, 32'(st_a), 32'(e.st));
                chk("outs_a", e.idx, 32'(act_a), 32'(e.o));
                chk("cnt_a", e.idx, 32'(cnt_a), 32'(e.cnt));
            end
            if (e.c2) begin
                chk("state_b", e.idx, 32'(st_b), 32'(e.st));
                chk("outs_b", e.idx, 32'(act_b), 32'(e.o));
                chk("cnt_b", e.idx, 32'(cnt_b), 32'(e.cnt[1:0]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_wait.md
Name: multicycle_ctrl_wait

Overview:
- Parametrised successor to the multicycle CPU control FSM.
- Same 16-opcode ISA and datapath control signal set as the current control unit, plus:
  - memory wait-state handshake (MemReq/MemReady),
  - external pipeline-style stall,
  - illegal-opcode trap,
  - retired-instruction counter.
- Sits between the instruction register opcode field and the multicycle datapath/memory controller.

Parameters:
OPCODE_W, 4, opcode field width (>=4); any opcode value >15 is illegal.
CNT_W, 16, width of retired-instruction counter.

Ports:
CLK  in  1  clock, all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
Opcode  in  OPCODE_W  opcode from IR, sampled in DECODE and later states.
MemReady  in  1  memory completes current MemReq access this cycle.
Stall  in  1  freezes FSM in DECODE (hazard/debug hold).
MemReq  out  1  memory access requested (read or write).
MemRead, MemWrite  out  1 each  access type qualifiers, valid while MemReq=1.
IRWrite, MDRWrite, PCWrite, RegWrite, Beq, Bne  out  1 each  datapath strobes.
IorD, PCSource, ALUSrc1, ALUSrc2, ALUoutSrc  out  2 each  datapath mux selects.
ALUOp, RegSrc  out  3 each  ALU function, register write-data select.
current_state  out  5  encoded state, for debug.
Trap  out  1  illegal opcode seen; sticky until Reset.
InstrCount  out  CNT_W  instructions retired since Reset.

Behaviour:
- **Reset** (sync, rising CLK with Reset=1):
  - state=FETCH (0), InstrCount=0, Trap=0.
  - Reset overrides MemReady, Stall and any in-flight access; an access aborted by Reset is not retried.
- **Output style:** Moore outputs decoded combinationally from state. Opcode-dependent ALUOp in R_EXEC/I_EXEC only. Every output has a default of 0 in every state; no latches.
- **States and per-state outputs:**
  - FETCH (0): MemReq=1, MemRead=1, IorD=0, ALUSrc1=2, ALUSrc2=2, ALUOp=2, PCSource=1, ALUoutSrc=1. IRWrite and PCWrite assert only in the cycle MemReady=1. Otherwise stay in FETCH (wait state).
  - DECODE (1): ALUSrc1=0, ALUSrc2=2.
    - Stall=1: hold DECODE.
    - Else dispatch on Opcode: 0-4 R_EXEC; 5 JR; 6,10 ADDR; 7 JAL; 8,9 BR_EXEC; 11-13 I_EXEC; 14 LUI; 15 LI; >15 TRAP.
  - R_EXEC (2): ALUSrc1=3, ALUSrc2=0, ALUoutSrc=3. ALUOp by opcode: 0→2, 1→0, 2→1, 3→6, 4→7. Next R_WRITE.
  - R_WRITE (3): RegWrite=1, RegSrc=4. Next FETCH.
  - ADDR (4): ALUoutSrc=3. Next: op 6 → SW_MEM, op 10 → LW_MEM.
  - LW_MEM (5): MemReq=1, MemRead=1, IorD=1. MDRWrite=1 only when MemReady. Leave on MemReady to LW_WB, else wait.
  - SW_MEM (6): MemReq=1, MemWrite=1, IorD=1. Leave on MemReady to FETCH, else wait. MemWrite stays high throughout the wait.
  - LW_WB (7): RegWrite=1, RegSrc=1. Next FETCH.
  - JR (9): PCWrite=1, PCSource=1, IorD=2. Next FETCH.
  - BR_EXEC (10): ALUSrc1=1, ALUSrc2=0, ALUOp=6. Next: op 8 → BEQ_DONE, op 9 → BNE_DONE.
  - BNE_DONE (11): PCWrite=1, Bne=1. Next FETCH.
  - BEQ_DONE (12): PCWrite=1, Beq=1. Next FETCH.
  - JAL (13): RegWrite=1, RegSrc=3, PCWrite=1, PCSource=2. Next FETCH.
  - I_EXEC (14): ALUSrc1=0, ALUSrc2=0. ALUOp: 11→2, 12→0, 13→1. Next I_WRITE.
  - I_WRITE (15): RegWrite=1, RegSrc=4. Next FETCH.
  - LUI (16): RegWrite=1, RegSrc=2. Next FETCH.
  - LI (17): RegWrite=1, ALUoutSrc=2. Next FETCH.
  - TRAP (18): all strobes 0, Trap=1. Absorbing until Reset.
- **Unexpected opcodes / encodings:**
  - In ADDR, BR_EXEC or I_EXEC, an opcode outside the listed set goes to TRAP.
  - Any unused state encoding goes to FETCH.
- **InstrCount:** increments by 1 on each transition into FETCH from a non-FETCH state (instruction retired). Wraps modulo 2^CNT_W. TRAP entry does not count.
- **MemReady outside MemReq:** ignored.
- **Stall outside DECODE:** ignored.
- **Latency, zero-wait memory:** R-type 4 cycles, LW 5, SW 4, branch 4, J/JR/LUI/LI/JAL 3. Each wait cycle adds 1.

Test Plan:
- Reset, then opcode 0 with MemReady tied 1: states 0,1,2,3,0. ALUOp=2 in R_EXEC. RegWrite=1 only in state 3. InstrCount=1.
- Opcode 10 with MemReady low 3 cycles in FETCH and 2 in LW_MEM: IRWrite pulses once. MDRWrite pulses once, in the MemReady cycle. Total 10 cycles, InstrCount=1.
- Opcode 6 with MemReady delayed: MemWrite held high until MemReady. Then FETCH, no RegWrite at any time.
- Opcode 9 then opcode 8 back to back: BNE_DONE asserts Bne=1/PCWrite=1 for 1 cycle. BEQ_DONE asserts Beq=1/PCWrite=1 for 1 cycle. InstrCount=2.
- OPCODE_W=5, opcode 20: DECODE→TRAP. Trap=1 held 10 cycles regardless of inputs. Reset clears to FETCH with Trap=0.
- Stall=1 for 4 cycles in DECODE, then Reset asserted while in LW_MEM: DECODE held 4 cycles. Next edge after Reset gives state 0, InstrCount=0. CNT_W=2 run of 5 instructions: InstrCount wraps to 1.
